upower_multicycle_sequencer: RTL
================================

// Module: upower_multicycle_sequencer
// PURPOSE
//   Multicycle control FSM for the uPOWER 64-bit datapath (PC, IR, RegFile, ALU, DataMemory).
//   Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues one-cycle write enables.
//   Handshakes with instruction and data memories via req/ready, with a wait-state watchdog.
//   Sits beside the combinational Control_Unit; CU still drives ALU_OP/ALUSrc/RegDst/reg1/reg2.
// PARAMETERS
//   OP_LD    6'd58  ld opcode (instruction[31:26])
//   OP_STD   6'd62  std opcode
//   OP_ADDI  6'd14  addi opcode
//   OP_XO    6'd31  X/XO-form ALU ops (add, sub, and, ...)
//   OP_ANDI  6'd28  andi opcode
//   OP_ORI   6'd24  ori opcode
//   OP_BEQ   6'd19  branch if zero_flag=1
//   OP_BNE   6'd20  branch if zero_flag=0
//   TIMEOUT  16     max wait cycles on a memory req before ERROR; 0 disables watchdog
//   CNT_W    16     retired-instruction counter width
// PORTS
//   clk           in   1      clock, rising edge
//   rst           in   1      asynchronous, active-low reset
//   opcode        in   6      IR[31:26]; stable from DECODE through end of instruction
//   zero_flag     in   1      ALU zero flag, valid in EXEC
//   imem_ready    in   1      instruction memory completes fetch this cycle
//   dmem_ready    in   1      data memory completes access this cycle
//   imem_req      out  1      fetch request
//   ir_write      out  1      load IR (one-cycle pulse)
//   pc_write      out  1      update PC (one-cycle pulse)
//   pc_src        out  1      1: PC <= branch target, 0: PC <= PC+4
//   dmem_req      out  1      data memory request
//   dmem_we       out  1      1: write (std), 0: read (ld); meaningful only with dmem_req
//   reg_write     out  1      RegFile write enable (one-cycle pulse)
//   mem_to_reg    out  1      1: write-back from readData
//   halted        out  1      sticky, HALT state
//   error         out  1      sticky, ERROR state (illegal opcode or watchdog)
//   state         out  3      current state encoding
//   retired       out  CNT_W  completed-instruction count
// BEHAVIOUR
//   States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 ERROR=7.
//   Reset (rst=0, async): state=IDLE, retired=0, wait counter=0, all outputs 0.
//     Reset mid-instruction aborts it; no write pulse is issued.
//   IDLE: unconditionally -> FETCH next cycle.
//   FETCH: imem_req=1. On imem_ready: ir_write=1, -> DECODE. Otherwise stay.
//   DECODE: classify opcode and latch the class.
//     opcode 0 -> HALT. Listed opcode -> EXEC. Any other opcode -> ERROR.
//   EXEC:
//     Branch: pc_write=1; pc_src = (BEQ & zero_flag) | (BNE & ~zero_flag), Mealy on zero_flag; -> FETCH.
//     ALU class (ADDI/XO/ANDI/ORI): -> WB.
//     LD/STD: -> MEM.
//   MEM: dmem_req=1; dmem_we=1 iff STD. On dmem_ready:
//     LD -> WB.
//     STD: pc_write=1 in the same cycle, -> FETCH.
//   WB: reg_write=1, pc_write=1, pc_src=0, mem_to_reg=(LD); -> FETCH.
//   HALT/ERROR: absorbing until reset; all pulse/req outputs 0.
//   Watchdog: counter clears on entry to FETCH/MEM and counts each cycle req is high without ready.
//     If TIMEOUT!=0 and the count reaches TIMEOUT: -> ERROR; req drops the next cycle.
//     If ready and timeout coincide, ready wins.
//   retired: +1 on every pc_write cycle; wraps modulo 2^CNT_W.
//   Latency with ready asserted immediately:
//     branch 3 cycles, ALU 4, std 4, ld 5 (FETCH through final pc_write).
//   imem_ready/dmem_ready are ignored when the matching req is low.
//   pc_src=0 whenever pc_write=0.
// TESTING
//   T1: reset release, imem_ready=1, opcode=14 -> state 0,1,2,3,5,1.
//       reg_write=pc_write=1 in WB only; mem_to_reg=0; retired=1.
//   T2: opcode=58, dmem_ready rises 3 cycles after MEM entry -> dmem_req=1 for 4 cycles, dmem_we=0.
//       Then WB with mem_to_reg=1, reg_write=1.
//   T3: opcode=62 with dmem_ready=1 -> one MEM cycle, dmem_we=1, pc_write=1 there, reg_write never 1.
//   T4: opcode=19, zero_flag=1 -> EXEC pc_write=1, pc_src=1.
//       opcode=20, zero_flag=1 -> pc_write=1, pc_src=0; reg_write=0 in both.
//   T5: TIMEOUT=8, opcode=58, dmem_ready held 0 -> ERROR after 8 MEM cycles, error=1, dmem_req=0.
//       Separately, opcode=5 -> ERROR straight from DECODE.
//   T6: opcode=0 -> halted=1, stays halted.
//       rst pulsed low during MEM -> all outputs 0 at once, retired=0, restart at IDLE->FETCH.

Source files
------------

// File: rtl/upower_multicycle_sequencer.sv
// Multicycle control sequencer for the uPOWER 64-bit datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives one-cycle write enables.
module upower_multicycle_sequencer #(
  parameter logic [5:0]  OP_LD   = 6'd58,
  parameter logic [5:0]  OP_STD  = 6'd62,
  parameter logic [5:0]  OP_ADDI = 6'd14,
  parameter logic [5:0]  OP_XO   = 6'd31,
  parameter logic [5:0]  OP_ANDI = 6'd28,
  parameter logic [5:0]  OP_ORI  = 6'd24,
  parameter logic [5:0]  OP_BEQ  = 6'd19,
  parameter logic [5:0]  OP_BNE  = 6'd20,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero_flag,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU = 3'd0,
    C_LD  = 3'd1,
    C_STD = 3'd2,
    C_BEQ = 3'd3,
    C_BNE = 3'd4
  } cls_t;

  // Counter only needs to hold TIMEOUT-1: the step that would reach TIMEOUT goes to ERROR instead.
  localparam int unsigned         WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam bit                  WDOG_EN   = (TIMEOUT != 0);

  state_t             r_state;
  state_t             w_state_nxt;
  cls_t               r_cls;
  cls_t               w_cls_dec;
  logic               w_legal;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_retired;
  logic               w_req;
  logic               w_rdy;
  logic               w_timeout;

  assign w_req     = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_rdy     = ((r_state == S_FETCH) && imem_ready) || ((r_state == S_MEM) && dmem_ready);
  assign w_timeout = WDOG_EN && w_req && !w_rdy && (r_wait == WAIT_LAST);

  assign state   = r_state;
  assign retired = r_retired;

  always_comb begin
    w_cls_dec = C_ALU;
    w_legal   = 1'b1;
    case (opcode)
      OP_LD:                            w_cls_dec = C_LD;
      OP_STD:                           w_cls_dec = C_STD;
      OP_BEQ:                           w_cls_dec = C_BEQ;
      OP_BNE:                           w_cls_dec = C_BNE;
      OP_ADDI, OP_XO, OP_ANDI, OP_ORI:  w_cls_dec = C_ALU;
      default:                          w_legal   = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    error       = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        if (imem_ready)     w_state_nxt = S_DECODE;
        else if (w_timeout) w_state_nxt = S_ERROR;
      end
      S_DECODE: begin
        if (opcode == 6'd0) w_state_nxt = S_HALT;
        else if (w_legal)   w_state_nxt = S_EXEC;
        else                w_state_nxt = S_ERROR;
      end
      S_EXEC: begin
        case (r_cls)
          C_BEQ, C_BNE: begin
            pc_write    = 1'b1;
            pc_src      = ((r_cls == C_BEQ) && zero_flag) || ((r_cls == C_BNE) && !zero_flag);
            w_state_nxt = S_FETCH;
          end
          C_LD, C_STD: w_state_nxt = S_MEM;
          default:     w_state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_cls == C_STD);
        if (dmem_ready) begin
          if (r_cls == C_STD) begin
            pc_write    = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_WB: begin
        reg_write   = 1'b1;
        pc_write    = 1'b1;
        mem_to_reg  = (r_cls == C_LD);
        w_state_nxt = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: error  = 1'b1;
      default: w_state_nxt = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cls     <= C_ALU;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) r_cls <= w_cls_dec;
      if ((w_state_nxt != r_state) && ((w_state_nxt == S_FETCH) || (w_state_nxt == S_MEM)))
        r_wait <= '0;
      else if (w_req && !w_rdy)
        r_wait <= r_wait + WAIT_W'(1);
      if (pc_write) r_retired <= r_retired + CNT_W'(1);
    end
  end

endmodule
